temp_spi_poller: RTL and testbench

Parametrised poller for the board's SPI digital temperature sensors, which share one SCK/CSN and have one SO line per sensor. It runs one shared read-only SPI frame, shifts all SO lines in parallel, publishes one signed word per channel and drives per-channel heater enables with hysteresis and sensor-fault cut-off. It sits between the temperature-sensor pins and the heater outputs (CTR-style enables) in the FPGA top.

---
 rtl/temp_spi_poller_if.sv | 49 ++++
 rtl/temp_spi_poller.sv | 175 +++++++++++++++++
 tb/tb_temp_spi_poller.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/temp_spi_poller_if.sv
// temp_spi_poller_if
// Groups the request/heater controls, the shared SPI sensor pins and the
// per-channel results of temp_spi_poller into one bundle.
//
// Handshake: there is no back-pressure. "start" is a single-cycle request
// that the poller takes only while idle and drops otherwise. "data_valid" is
// a single-cycle pulse that marks the edge on which temp_data, fault and
// heat_on take new values. The consumer must be ready on every cycle.
//
// Signals (direction as seen by the poller, modport master):
//   start, auto_en, heat_en   in   request / periodic enable / heater enable
//   heat_lo, heat_hi          in   signed turn-on / turn-off thresholds
//   temp_so                   in   one SO line per sensor
//   temp_sck, temp_csn        out  shared SPI clock (idles low) and chip select
//   temp_data                 out  channel i in [i*DATA_W +: DATA_W]
//   data_valid, busy          out  result pulse, frame or guard gap running
//   fault, heat_on            out  per-channel open-SO flag and heater enable
//   dbg_state                 out  current FSM state encoding
interface temp_spi_poller_if #(
  parameter int CH_NUM = 3,
  parameter int DATA_W = 16
) ();
  logic                       start;
  logic                       auto_en;
  logic                       heat_en;
  logic [DATA_W-1:0]          heat_lo;
  logic [DATA_W-1:0]          heat_hi;
  logic                       temp_sck;
  logic                       temp_csn;
  logic [CH_NUM-1:0]          temp_so;
  logic [CH_NUM*DATA_W-1:0]   temp_data;
  logic                       data_valid;
  logic                       busy;
  logic [CH_NUM-1:0]          fault;
  logic [CH_NUM-1:0]          heat_on;
  logic [2:0]                 dbg_state;

  modport master (
    input  start, auto_en, heat_en, heat_lo, heat_hi, temp_so,
    output temp_sck, temp_csn, temp_data, data_valid, busy, fault, heat_on,
           dbg_state
  );

  modport slave (
    output start, auto_en, heat_en, heat_lo, heat_hi, temp_so,
    input  temp_sck, temp_csn, temp_data, data_valid, busy, fault, heat_on,
           dbg_state
  );
endinterface

// File: rtl/temp_spi_poller.sv
// temp_spi_poller
// Runs one read-only SPI frame shared by CH_NUM temperature sensors, shifts
// all SO lines in parallel (MSB first), publishes one signed word per
// channel and drives per-channel heater enables with hysteresis and an
// open-sensor cut-off. Frames start on "start" or on the auto-poll tick.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    temp_spi_poller_if.master (controls, SPI pins, results, state)
module temp_spi_poller #(
  parameter int CH_NUM = 3,
  parameter int DATA_W = 16,
  parameter int DIV    = 4,
  parameter int PERIOD = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  temp_spi_poller_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_LO = 3'd2,
    SCK_HI = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } state_e;

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(DATA_W + 1);
  localparam int PCW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BITS     = BCW'(DATA_W);
  localparam logic [PCW-1:0] PER_LAST = PCW'(PERIOD - 1);

  state_e                           state_q, state_d;
  logic [DCW-1:0]                   div_q, div_d;
  logic [BCW-1:0]                   bit_q, bit_d;
  logic [CH_NUM-1:0][DATA_W-1:0]    sh_q, sh_d;
  logic [PCW-1:0]                   per_q, per_d;
  logic                             pend_q, pend_d;
  logic                             sck_q, sck_d;
  logic                             csn_q, csn_d;
  logic [CH_NUM*DATA_W-1:0]         data_q, data_d;
  logic                             valid_q, valid_d;
  logic [CH_NUM-1:0]                fault_q, fault_d;
  logic [CH_NUM-1:0]                heat_q, heat_d;
  logic                             div_last;
  logic                             auto_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      per_q   <= '0;
      pend_q  <= 1'b0;
      sck_q   <= 1'b0;
      csn_q   <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= '0;
      heat_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      sck_q   <= sck_d;
      csn_q   <= csn_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      heat_q  <= heat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fault_d = fault_q;
    heat_d  = heat_q;

    div_last  = (div_q == DIV_LAST);
    auto_tick = bus.auto_en && (per_q == PER_LAST);

    // Free-running poll counter; parked at 0 while auto mode is off.
    if (!bus.auto_en)  per_d = '0;
    else if (auto_tick) per_d = '0;
    else               per_d = per_q + 1'b1;

    // Every non-idle state lasts DIV cycles; the counter restarts per state.
    if (state_q == IDLE || div_last) div_d = '0;
    else                             div_d = div_q + 1'b1;

    // A tick that lands while a frame runs is remembered once; in IDLE any
    // request (including a held one) is consumed immediately.
    if (!bus.auto_en)          pend_d = 1'b0;
    else if (state_q == IDLE)  pend_d = 1'b0;
    else if (auto_tick)        pend_d = 1'b1;
    else                       pend_d = pend_q;

    case (state_q)
      IDLE: begin
        if (bus.start || auto_tick || pend_q) begin
          state_d = SETUP;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (div_last) state_d = SCK_LO;
      end
      SCK_LO: begin
        if (div_last) begin
          state_d = SCK_HI;
          bit_d   = bit_q + 1'b1;
          for (int c = 0; c < CH_NUM; c++) begin
            sh_d[c] = {sh_q[c][DATA_W-2:0], bus.temp_so[c]};
          end
        end
      end
      SCK_HI: begin
        if (div_last) state_d = (bit_q == BITS) ? HOLD : SCK_LO;
      end
      HOLD: begin
        if (div_last) begin
          state_d = GAP;
          valid_d = 1'b1;
          for (int c = 0; c < CH_NUM; c++) begin
            data_d[c*DATA_W +: DATA_W] = sh_q[c];
            if (&sh_q[c]) begin
              // A floating SO line reads as all ones: cut the heater.
              fault_d[c] = 1'b1;
              heat_d[c]  = 1'b0;
            end else begin
              fault_d[c] = 1'b0;
              // Turn-off is tested first so it wins if the thresholds cross.
              if ($signed(sh_q[c]) > $signed(bus.heat_hi))      heat_d[c] = 1'b0;
              else if ($signed(sh_q[c]) < $signed(bus.heat_lo)) heat_d[c] = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (div_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!bus.heat_en) heat_d = '0;

    // Pin levels are registered from the next state so they switch on the
    // same edge as the state change without decode glitches.
    sck_d = (state_d == SCK_HI);
    csn_d = (state_d == IDLE) || (state_d == GAP);
  end

  assign bus.temp_sck   = sck_q;
  assign bus.temp_csn   = csn_q;
  assign bus.temp_data  = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.fault      = fault_q;
  assign bus.heat_on    = heat_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_temp_spi_poller.sv
// tb_temp_spi_poller
// Directed bench for temp_spi_poller with CH_NUM=3, DATA_W=16, DIV=2,
// PERIOD=200. Three behavioural sensors shift their word out MSB first,
// advancing one bit after each SCK rise.
module tb_temp_spi_poller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  temp_spi_poller_if #(.CH_NUM(3), .DATA_W(16)) bus ();

  temp_spi_poller #(
    .CH_NUM(3), .DATA_W(16), .DIV(2), .PERIOD(200)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Sensor model
  logic [15:0] sensor_w [3];
  int          rise_cnt = 0;

  always @(posedge bus.temp_sck or negedge bus.temp_csn) begin
    if (bus.temp_sck) rise_cnt <= rise_cnt + 1;
    else              rise_cnt <= 0;
  end

  always_comb begin
    logic [2:0] so_v;
    so_v = '0;
    for (int c = 0; c < 3; c++) begin
      if (rise_cnt < 16) so_v[c] = sensor_w[c][15 - rise_cnt];
    end
    bus.temp_so = so_v;
  end

  // Bookkeeping, all updated at negedge sampling points
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int csn_low = 0;
  int rises = 0;
  int falls = 0;
  int dv_cnt = 0;
  int last_fall = 0;
  logic sck_prev = 1'b0;
  logic csn_prev = 1'b1;
  int c0, r0, d0, f0;
  int fa, fb, fc, fd, fs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!bus.temp_csn) csn_low++;
    if (bus.temp_sck && !sck_prev) rises++;
    if (!bus.temp_csn && csn_prev) begin
      falls++;
      last_fall = cyc;
    end
    if (bus.data_valid) dv_cnt++;
    sck_prev = bus.temp_sck;
    csn_prev = bus.temp_csn;
  endtask

  task automatic wait_dv();
    int i;
    for (i = 0; i < 200; i++) begin
      if (bus.data_valid) break;
      tick();
    end
    if (i == 200) check("dv_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_fall(output int at);
    int n;
    int i;
    n = falls;
    for (i = 0; i < 300; i++) begin
      tick();
      if (falls != n) break;
    end
    if (i == 300) check("fall_timeout", 64'd0, 64'd1);
    at = last_fall;
  endtask

  task automatic settle();
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      tick();
    end
    tick();
  endtask

  task automatic run_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    sensor_w[0] = w0;
    sensor_w[1] = w1;
    sensor_w[2] = w2;
    c0 = csn_low;
    r0 = rises;
    d0 = dv_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_dv();
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.auto_en = 1'b0;
    bus.heat_en = 1'b0;
    bus.heat_lo = 16'h0000;
    bus.heat_hi = 16'h0000;
    sensor_w[0] = 16'h0000;
    sensor_w[1] = 16'h0000;
    sensor_w[2] = 16'h0000;

    // Reset values
    repeat (3) tick();
    check("rst_csn", bus.temp_csn, 1);
    check("rst_sck", bus.temp_sck, 0);
    check("rst_data", bus.temp_data, 0);
    check("rst_dv", bus.data_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_heat", bus.heat_on, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Manual read
    run_frame(16'h1234, 16'hFF38, 16'h7FFF);
    check("man_data", bus.temp_data, 48'h7FFF_FF38_1234);
    check("man_dv", bus.data_valid, 1);
    check("man_csn_up", bus.temp_csn, 1);
    check("man_busy_dv", bus.busy, 1);
    check("man_csn_low", csn_low - c0, 68);
    check("man_rises", rises - r0, 16);
    check("man_fault", bus.fault, 0);
    tick();
    check("man_dv_1cyc", bus.data_valid, 0);
    check("man_busy_p1", bus.busy, 1);
    tick();
    check("man_busy_p2", bus.busy, 0);
    check("man_dv_cnt", dv_cnt - d0, 1);
    settle();

    // Busy rejection: start mid-frame and in GAP
    d0 = dv_cnt;
    f0 = falls;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_dv();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (100) tick();
    check("rej_dv_cnt", dv_cnt - d0, 1);
    check("rej_frames", falls - f0, 1);

    // Auto mode
    sensor_w[0] = 16'h0100;
    sensor_w[1] = 16'h0200;
    sensor_w[2] = 16'h0300;
    bus.auto_en = 1'b1;
    wait_fall(fa);
    wait_fall(fb);
    check("auto_period", fb - fa, 200);
    // start lands on the same edge as the next tick
    repeat (199) tick();
    fs = falls;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("coinc_fall", falls - fs, 1);
    fc = last_fall;
    check("coinc_period", fc - fb, 200);
    wait_fall(fd);
    check("coinc_no_extra", fd - fc, 200);
    repeat (20) tick();
    bus.auto_en = 1'b0;
    d0 = dv_cnt;
    f0 = falls;
    repeat (400) tick();
    check("autooff_finish", dv_cnt - d0, 1);
    check("autooff_nomore", falls - f0, 0);
    check("autooff_data", bus.temp_data, 48'h0300_0200_0100);

    // Hysteresis, ch1 always hot, ch2 always cold
    bus.heat_en = 1'b1;
    bus.heat_lo = 16'h0010;
    bus.heat_hi = 16'h0020;
    run_frame(16'h0005, 16'h7FFF, 16'h0000);
    check("hys_1", bus.heat_on, 3'b101);
    settle();
    run_frame(16'h0018, 16'h7FFF, 16'h0000);
    check("hys_2", bus.heat_on, 3'b101);
    settle();
    run_frame(16'h0025, 16'h7FFF, 16'h0000);
    check("hys_3", bus.heat_on, 3'b100);
    settle();
    run_frame(16'h0018, 16'h7FFF, 16'h0000);
    check("hys_4", bus.heat_on, 3'b100);
    settle();
    run_frame(16'hFFF0, 16'h7FFF, 16'h0000);
    check("hys_5", bus.heat_on, 3'b101);
    check("hys_fault", bus.fault, 3'b000);
    settle();
    bus.heat_lo = 16'h0030;
    run_frame(16'h0025, 16'h7FFF, 16'h0000);
    check("hys_cross", bus.heat_on, 3'b100);
    settle();

    // Fault and heat_en
    bus.heat_lo = 16'h0010;
    run_frame(16'h0005, 16'h0005, 16'h0005);
    check("flt_pre", bus.heat_on, 3'b111);
    settle();
    run_frame(16'h0005, 16'hFFFF, 16'h0005);
    check("flt_fault", bus.fault, 3'b010);
    check("flt_heat", bus.heat_on, 3'b101);
    check("flt_data", bus.temp_data, 48'h0005_FFFF_0005);
    settle();
    run_frame(16'h0005, 16'h0005, 16'h0005);
    check("flt_clear", bus.fault, 3'b000);
    check("flt_reheat", bus.heat_on, 3'b111);
    settle();
    bus.heat_en = 1'b0;
    tick();
    check("hen_off", bus.heat_on, 3'b000);
    run_frame(16'h0005, 16'h0005, 16'h0005);
    check("hen_off_frame", bus.heat_on, 3'b000);
    settle();
    bus.heat_en = 1'b1;
    run_frame(16'h0018, 16'h0018, 16'h0018);
    check("hen_hold0", bus.heat_on, 3'b000);
    settle();

    // Reset mid-frame after bit 7
    sensor_w[0] = 16'h1111;
    sensor_w[1] = 16'h2222;
    sensor_w[2] = 16'h3333;
    r0 = rises;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rises - r0 == 8) break;
      tick();
    end
    check("mid_rises", rises - r0, 8);
    rst_n = 1'b0;
    #1;
    check("mid_csn", bus.temp_csn, 1);
    check("mid_sck", bus.temp_sck, 0);
    check("mid_data", bus.temp_data, 0);
    check("mid_busy", bus.busy, 0);
    check("mid_dv", bus.data_valid, 0);
    check("mid_fault", bus.fault, 0);
    check("mid_heat", bus.heat_on, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    run_frame(16'hA5A5, 16'h0F0F, 16'h8001);
    check("post_data", bus.temp_data, 48'h8001_0F0F_A5A5);
    check("post_csn_low", csn_low - c0, 68);
    check("post_rises", rises - r0, 16);
    check("post_heat", bus.heat_on, 3'b101);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
